// File: rtl/bip_pkg.sv
// bip_pkg: shared BIP widths, opcode map and program-loader state encoding
package bip_pkg;
  localparam int NBITS_0 = 11;
  localparam int NBITS_D = 16;
  localparam int NBITS_B = 8;
  localparam int OPCODE  = 5;
  localparam logic [OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE-1:0] OP_SUBI = 5'b00111;
  typedef enum logic [2:0] {
    WAIT_HI = 3'd0,
    WAIT_LO = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERROR   = 3'd4
  } loader_state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: assembles UART bytes into instructions, writes program memory and holds the CPU in reset until HALT lands
module program_loader #(
  parameter int NBITS_0 = bip_pkg::NBITS_0,
  parameter int NBITS_D = bip_pkg::NBITS_D,
  parameter int NBITS_B = bip_pkg::NBITS_B,
  parameter int OPCODE  = bip_pkg::OPCODE,
  parameter logic [OPCODE-1:0] HALT_OP = bip_pkg::OP_HLT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS_B-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_reload,
  output logic               o_wr_en,
  output logic [NBITS_0-1:0] o_wr_addr,
  output logic [NBITS_D-1:0] o_wr_data,
  output logic               o_cpu_reset,
  output logic               o_loaded,
  output logic               o_error
);
  import bip_pkg::*;
  loader_state_t      state;
  logic [NBITS_0-1:0] counter;
  logic [NBITS_B-1:0] hi_byte;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= WAIT_HI;
      counter     <= '0;
      hi_byte     <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_cpu_reset <= 1'b1;
      o_loaded    <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        WAIT_HI: if (i_rx_done) begin
          hi_byte <= i_rx_data;
          state   <= WAIT_LO;
        end
        WAIT_LO: if (i_rx_done) begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= counter;
          o_wr_data <= {hi_byte, i_rx_data};
          state     <= WRITE;
        end
        WRITE: if (o_wr_data[NBITS_D-1 -: OPCODE] == HALT_OP) begin
          o_cpu_reset <= 1'b0;
          o_loaded    <= 1'b1;
          state       <= DONE;
        end else if (counter == '1) begin
          o_error <= 1'b1;
          state   <= ERROR;
        end else begin
          // a byte arriving during the write cycle is the next high byte
          counter <= counter + 1'b1;
          if (i_rx_done) hi_byte <= i_rx_data;
          state <= i_rx_done ? WAIT_LO : WAIT_HI;
        end
        DONE: if (i_reload) begin
          counter     <= '0;
          o_cpu_reset <= 1'b1;
          o_loaded    <= 1'b0;
          state       <= WAIT_HI;
        end
        ERROR: if (i_reload) begin
          counter <= '0;
          o_error <= 1'b0;
          state   <= WAIT_HI;
        end
        default: state <= WAIT_HI;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed byte streams checked against a word-level loader model
module tb_program_loader;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic        i_reload = 1'b0;
  logic        o_wr_en;
  logic [10:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_cpu_reset;
  logic        o_loaded;
  logic        o_error;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  logic       m_pend;
  logic [7:0] m_hi;
  int         m_addr;
  logic       m_loaded;
  logic       m_error;
  logic       prev_en = 1'b0;
  program_loader dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_reload(i_reload), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_cpu_reset(o_cpu_reset), .o_loaded(o_loaded), .o_error(o_error)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_pend = 0; m_hi = '0; m_addr = 0; m_loaded = 0; m_error = 0;
    exp_q.delete();
  endtask
  task automatic model_byte(input logic [7:0] b);
    logic [15:0] w;
    if (m_loaded || m_error) return;
    if (!m_pend) begin
      m_pend = 1; m_hi = b;
      return;
    end
    m_pend = 0;
    w = {m_hi, b};
    exp_q.push_back('{32'(m_addr), 32'(w)});
    if (w[15:11] == 5'b0) m_loaded = 1;
    else if (m_addr == 2047) m_error = 1;
    else m_addr++;
  endtask
  task automatic model_reload();
    if (m_loaded || m_error) begin
      m_loaded = 0; m_error = 0; m_addr = 0;
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    i_rx_data = b; i_rx_done = 1'b1;
    model_byte(b);
    @(negedge i_clk);
    i_rx_done = 1'b0; i_rx_data = 8'($urandom);
    repeat (gap) @(negedge i_clk);
  endtask
  task automatic reload();
    i_reload = 1'b1;
    model_reload();
    @(negedge i_clk);
    i_reload = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask
  task automatic check_flags(input string tag);
    check({tag, "_loaded"}, 32'(o_loaded), 32'(m_loaded));
    check({tag, "_error"}, 32'(o_error), 32'(m_error));
    check({tag, "_cpu_rst"}, 32'(o_cpu_reset), 32'(!m_loaded));
    check({tag, "_drain"}, 32'(exp_q.size()), 0);
  endtask
  task automatic async_reset();
    #2 i_reset = 1'b0;
    model_reset();
    #1;
    check("arst_wr_en", 32'(o_wr_en), 0);
    check("arst_addr", 32'(o_wr_addr), 0);
    check("arst_data", 32'(o_wr_data), 0);
    check("arst_cpu_rst", 32'(o_cpu_reset), 1);
    @(negedge i_clk);
    #2 i_reset = 1'b1;
    @(negedge i_clk);
  endtask
  always @(negedge i_clk) begin
    if (i_reset && o_wr_en) begin
      check("wr_single", 32'(prev_en), 0);
      if (exp_q.size() == 0) check("wr_unexpected", 32'(o_wr_en), 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(o_wr_addr), e.a);
        check("wr_data", 32'(o_wr_data), e.d);
      end
    end
    prev_en = o_wr_en;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    idle(3);
    check("rst_wr_en", 32'(o_wr_en), 0);
    check("rst_addr", 32'(o_wr_addr), 0);
    check("rst_data", 32'(o_wr_data), 0);
    check("rst_cpu_rst", 32'(o_cpu_reset), 1);
    check("rst_loaded", 32'(o_loaded), 0);
    check("rst_error", 32'(o_error), 0);
    #2 i_reset = 1'b1;
    idle(1);
    send(8'h08, 0);
    send(8'h05, 0);
    check("lat_n1", 32'(o_wr_en), 1);
    idle(1);
    check("lat_n2", 32'(o_wr_en), 0);
    send(8'h10, 0); send(8'h03, 0); send(8'h00, 0); send(8'h00, 0);
    check("halt_wr_en", 32'(o_wr_en), 1);
    check("halt_pre_loaded", 32'(o_loaded), 0);
    idle(1);
    check("halt_loaded", 32'(o_loaded), 1);
    check("halt_cpu_rst", 32'(o_cpu_reset), 0);
    check_flags("prog1");
    send(8'h12, 1); send(8'h34, 1);
    idle(3);
    check_flags("done_ignore");
    reload();
    check("reload_cpu_rst", 32'(o_cpu_reset), 1);
    check("reload_loaded", 32'(o_loaded), 0);
    send(8'h00, 0); send(8'h00, 0);
    idle(3);
    check_flags("reload_prog");
    reload();
    for (int i = 0; i < 2048; i++) begin
      send(8'h08, 0); send(8'h01, 0);
    end
    idle(1);
    check("full_error", 32'(o_error), 1);
    check("full_cpu_rst", 32'(o_cpu_reset), 1);
    send(8'h00, 1); send(8'h00, 1);
    idle(3);
    check_flags("full");
    reload();
    check("err_clear", 32'(o_error), 0);
    send(8'h00, 0); send(8'h00, 0);
    idle(3);
    check_flags("after_err");
    reload();
    send(8'h08, 1);
    async_reset();
    send(8'h00, 0); send(8'h00, 0);
    idle(3);
    check_flags("rst_mid_instr");
    reload();
    send(8'h08, 0); send(8'h05, 0);
    check("mid_wr_en", 32'(o_wr_en), 1);
    async_reset();
    send(8'h08, 0); send(8'h01, 2);
    send(8'h18, 1);
    reload();
    send(8'h07, 0);
    check("wait_lo_data", 32'(o_wr_data), 32'h1807);
    check("wait_lo_addr", 32'(o_wr_addr), 1);
    send(8'h00, 0); send(8'h00, 0);
    idle(3);
    check_flags("wait_lo_reload");
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [15:0] w;
      reload();
      n = int'($urandom_range(3, 30));
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        w[15:11] = 5'($urandom_range(1, 31));
        send(w[15:8], int'($urandom_range(0, 3)));
        send(w[7:0], int'($urandom_range(0, 3)));
        if ($urandom_range(0, 7) == 0) reload();
      end
      w = {5'b0, 11'($urandom)};
      send(w[15:8], int'($urandom_range(0, 2)));
      send(w[7:0], 0);
      idle(3);
      check_flags("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
